// File: rtl/naes_pkg.sv
// Shared NES system definitions: DMA state encoding and fixed bus register addresses.
package naes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: halts the CPU and copies one 256-byte page into PPU OAM via OAMDATA.
// Every state lasts one CPU cycle; all state advances only on ppu_clk edges with cpu_ce high.
module oam_dma
    import naes_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA = ADDR_OAMDATA,
    parameter int          NBYTES   = 256
) (
    input  logic        ppu_clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        odd_or_even,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic [7:0]  bus_rdata,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_wr,
    output logic        dma_done
);

    localparam logic [7:0] LAST_INDEX = 8'(NBYTES - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       trigger;

    assign trigger = cpu_ce && cpu_wr && (cpu_addr == DMA_REG);

    // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (cpu_ce) begin
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        page_d  = cpu_dout;
                        index_d = '0;
                        state_d = HALT;
                    end
                end
                HALT:  state_d = odd_or_even ? ALIGN : READ;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = bus_rdata;
                    state_d = WRITE;
                end
                WRITE: begin
                    // Termination is tested before the increment so the index never wraps.
                    if (index_q == LAST_INDEX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so nothing on cpu_* reaches dma_* combinationally.
    always_comb begin
        dma_hijack = 1'b0;
        dma_addr   = '0;
        dma_dout   = '0;
        dma_wr     = 1'b0;
        unique case (state_q)
            IDLE:  dma_hijack = 1'b0;
            HALT:  dma_hijack = 1'b1;
            ALIGN: dma_hijack = 1'b1;
            READ: begin
                dma_hijack = 1'b1;
                dma_addr   = {page_q, index_q};
            end
            WRITE: begin
                dma_hijack = 1'b1;
                dma_addr   = OAM_DATA;
                dma_dout   = data_q;
                dma_wr     = 1'b1;
            end
            default: dma_hijack = 1'b0;
        endcase
    end

    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: CPU strobe every third ppu_clk, bus data derived from the DMA address.
module tb_oam_dma;

    logic        ppu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic        odd_or_even = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  bus_rdata;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_wr;
    logic        dma_done;

    logic [7:0] salt = '0;
    int checks = 0;
    int errors = 0;

    // Memory model: every byte reads as its low address bits XOR a per-test salt.
    assign bus_rdata = dma_addr[7:0] ^ salt;

    always #5 ppu_clk = ~ppu_clk;

    oam_dma dut (
        .ppu_clk     (ppu_clk),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .odd_or_even (odd_or_even),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_wr      (cpu_wr),
        .bus_rdata   (bus_rdata),
        .dma_hijack  (dma_hijack),
        .dma_addr    (dma_addr),
        .dma_dout    (dma_dout),
        .dma_wr      (dma_wr),
        .dma_done    (dma_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit ce, input bit rst);
        @(negedge ppu_clk);
        cpu_ce = ce;
        reset  = rst;
        @(posedge ppu_clk);
        #1;
    endtask

    task automatic cpu_cycle();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    // One full transfer; optional mid-transfer trigger, cpu_ce stall or reset at CPU cycle k.
    task automatic run_xfer(input logic [7:0] page, input bit odd, input logic [7:0] s,
                            input int inject_k, input int stall_k, input int reset_k);
        int k;
        int offset;
        int j;
        int cycles;
        int writes;
        int dones;
        logic [15:0] snap_addr;
        logic [7:0]  snap_dout;
        logic        snap_wr;

        salt        = s;
        odd_or_even = odd;
        cpu_addr    = 16'h4014;
        cpu_wr      = 1'b1;
        cpu_dout    = page;
        cpu_cycle();
        cpu_addr = '0;
        cpu_wr   = 1'b0;
        cpu_dout = '0;
        check("hijack_rise", 32'(dma_hijack), 32'd1);

        offset = odd ? 2 : 1;
        k      = 0;
        cycles = 0;
        writes = 0;
        dones  = 0;
        while (dma_hijack && k < 600) begin
            cycles++;
            if (k == reset_k) begin
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b1);
                check("rst_hijack", 32'(dma_hijack), 32'd0);
                check("rst_wr", 32'(dma_wr), 32'd0);
                check("rst_done", 32'(dma_done), 32'd0);
                check("rst_addr", 32'(dma_addr), 32'd0);
                tick(1'b0, 1'b0);
                cpu_cycle();
                check("rst_no_done", 32'(dma_done), 32'd0);
                check("rst_stays_idle", 32'(dma_hijack), 32'd0);
                return;
            end
            if (k < offset) begin
                check("halt_addr", 32'(dma_addr), 32'd0);
                check("halt_wr", 32'(dma_wr), 32'd0);
            end else begin
                j = k - offset;
                if (j % 2 == 0) begin
                    check("read_addr", 32'(dma_addr), 32'({page, 8'(j / 2)}));
                    check("read_wr", 32'(dma_wr), 32'd0);
                end else begin
                    check("write_addr", 32'(dma_addr), 32'h2004);
                    check("write_wr", 32'(dma_wr), 32'd1);
                    check("write_data", 32'(dma_dout), 32'(8'(j / 2) ^ s));
                end
            end
            if (dma_wr) writes++;
            if (k == stall_k) begin
                snap_addr = dma_addr;
                snap_dout = dma_dout;
                snap_wr   = dma_wr;
                repeat (10) begin
                    tick(1'b0, 1'b0);
                    check("stall_addr", 32'(dma_addr), 32'(snap_addr));
                    check("stall_dout", 32'(dma_dout), 32'(snap_dout));
                    check("stall_wr", 32'(dma_wr), 32'(snap_wr));
                    check("stall_hijack", 32'(dma_hijack), 32'd1);
                end
            end
            if (k == inject_k) begin
                cpu_addr = 16'h4014;
                cpu_wr   = 1'b1;
                cpu_dout = ~page;
            end
            cpu_cycle();
            cpu_addr = '0;
            cpu_wr   = 1'b0;
            cpu_dout = '0;
            if (dma_done) dones++;
            check("done_timing", 32'(dma_done), 32'(!dma_hijack));
            k++;
        end
        check("xfer_cycles", 32'(cycles), 32'(odd ? 514 : 513));
        check("xfer_writes", 32'(writes), 32'd256);
        check("xfer_dones", 32'(dones), 32'd1);
        tick(1'b0, 1'b0);
        check("done_pulse_width", 32'(dma_done), 32'd0);
        cpu_cycle();
        check("idle_after", 32'(dma_hijack), 32'd0);
    endtask

    initial begin
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("reset_hijack", 32'(dma_hijack), 32'd0);
        check("reset_wr", 32'(dma_wr), 32'd0);
        check("reset_done", 32'(dma_done), 32'd0);
        check("reset_addr", 32'(dma_addr), 32'd0);
        check("reset_dout", 32'(dma_dout), 32'd0);

        // Writes elsewhere and reads of $4014 must not trigger.
        cpu_addr = 16'h4015;
        cpu_wr   = 1'b1;
        cpu_dout = 8'h02;
        cpu_cycle();
        check("no_trig_other_addr", 32'(dma_hijack), 32'd0);
        cpu_addr = 16'h4014;
        cpu_wr   = 1'b0;
        cpu_cycle();
        check("no_trig_read", 32'(dma_hijack), 32'd0);
        cpu_addr = '0;
        cpu_dout = '0;

        run_xfer(8'h02, 1'b0, 8'h5A, -1, -1, -1);   // even start
        run_xfer(8'h02, 1'b1, 8'h5A, -1, -1, -1);   // odd start
        run_xfer(8'hFF, 1'b0, 8'h00, -1, -1, -1);   // top page, data = addr[7:0]
        run_xfer(8'h04, 1'b0, 8'hA5, 50, -1, -1);   // trigger mid-transfer
        run_xfer(8'h05, 1'b1, 8'h3C, 513, -1, -1);  // trigger on the done edge
        run_xfer(8'h06, 1'b0, 8'h5A, -1, -1, 201);  // reset during READ of byte 100
        run_xfer(8'h07, 1'b0, 8'h11, -1, -1, -1);   // restart from index 0
        run_xfer(8'h08, 1'b0, 8'h5A, -1, 21, -1);   // cpu_ce stall during READ

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
